// File: rtl/cpu_pkg.sv
// Definitions shared by the instruction sequencer, the mini-CPU and the LCD driver:
// instruction width, opcode field position and the sequencer state encoding.
package cpu_pkg;

  localparam int INSTR_W   = 18;
  localparam int OPCODE_HI = 17;
  localparam int OPCODE_LO = 15;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2
  } seq_state_t;

  function automatic logic [OPCODE_HI-OPCODE_LO:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Circular instruction FIFO. A push into a full FIFO is still accepted when a pop
// happens in the same cycle; clear empties it and drops any concurrent push.
module seq_fifo #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 18,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_data,
  input  logic               pop,
  output logic [INSTR_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               push_accept,
  output logic               push_drop
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               pop_ok;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign pop_ok      = pop && !clear && !empty;
  assign push_accept = push && !clear && (!full || pop_ok);
  assign push_drop   = push && !clear && full && !pop_ok;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)      rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_accept, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Queues instructions from the front end and issues them one at a time to the CPU,
// waiting for its completion pulse (or the watchdog) before issuing the next.
module instr_sequencer #(
  parameter int DEPTH       = 8,
  parameter int INSTR_W     = cpu_pkg::INSTR_W,
  parameter int TIMEOUT_CYC = 1024,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic [INSTR_W-1:0]  push_instr,
  input  logic                run_mode,
  input  logic                step,
  input  logic                flush,
  output logic                issue_valid,
  output logic [INSTR_W-1:0]  issue_instr,
  input  logic                issue_ready,
  input  logic                cpu_done,
  output logic [PTR_W:0]      count,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                timeout_err,
  output logic                busy,
  output cpu_pkg::seq_state_t dbg_state,
  output logic                dbg_step_pending
);

  import cpu_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  seq_state_t         state, state_next;
  logic [WD_W-1:0]    wd;
  logic [INSTR_W-1:0] head;
  logic               step_pending;
  logic               fifo_pop, load, set_timeout;
  logic               push_accept, push_drop;

  seq_fifo #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (flush),
    .push        (push),
    .push_data   (push_instr),
    .pop         (fifo_pop),
    .head        (head),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .push_accept (push_accept),
    .push_drop   (push_drop)
  );

  // Handshake: the CPU takes issue_instr on a rising edge where issue_valid and
  // issue_ready are both 1; issue_valid then holds low until the next issue.
  assign issue_valid      = (state == SEQ_ISSUE);
  assign busy             = (state != SEQ_IDLE);
  assign dbg_state        = state;
  assign dbg_step_pending = step_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SEQ_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    fifo_pop    = 1'b0;
    load        = 1'b0;
    set_timeout = 1'b0;
    case (state)
      SEQ_IDLE: begin
        // A flush in this cycle empties the queue, so nothing may be issued from it.
        if (!empty && !flush && (run_mode || step_pending)) begin
          load       = 1'b1;
          state_next = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        if (flush) begin
          state_next = SEQ_IDLE;
        end else if (issue_ready) begin
          fifo_pop   = 1'b1;
          state_next = SEQ_WAIT;
        end
      end
      SEQ_WAIT: begin
        if (cpu_done) begin
          state_next = SEQ_IDLE;
        end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
          set_timeout = 1'b1;
          state_next  = SEQ_IDLE;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd           <= '0;
      issue_instr  <= '0;
      step_pending <= 1'b0;
      overflow     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      wd <= (state == SEQ_WAIT) ? wd + WD_W'(1) : '0;
      if (load) issue_instr <= head;

      // A step arriving together with an issue arms the following issue.
      if (flush)                                                   step_pending <= 1'b0;
      else if (step && !run_mode && (!empty || push_accept))       step_pending <= 1'b1;
      else if (load)                                               step_pending <= 1'b0;

      if (flush)          overflow <= 1'b0;
      else if (push_drop) overflow <= 1'b1;

      if (flush)            timeout_err <= 1'b0;
      else if (set_timeout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: scoreboard of pushed instructions checked
// against every accepted issue, plus directed checks of timing, watchdog and flush.
module tb_instr_sequencer;
  import cpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 18;
  localparam int TOC   = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         push = 1'b0;
  logic [W-1:0] push_instr = '0;
  logic         run_mode = 1'b0;
  logic         step = 1'b0;
  logic         flush = 1'b0;
  logic         issue_valid;
  logic [W-1:0] issue_instr;
  logic         issue_ready = 1'b0;
  logic         cpu_done;
  logic [3:0]   count;
  logic         empty, full, overflow, timeout_err, busy;
  seq_state_t   dbg_state;
  logic         dbg_step_pending;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int cpu_auto = 0;
  int done_delay = 5;
  logic [W-1:0] exp_q[$];

  instr_sequencer #(.DEPTH(DEPTH), .INSTR_W(W), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .push_instr(push_instr),
    .run_mode(run_mode), .step(step), .flush(flush),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
    .cpu_done(cpu_done), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .timeout_err(timeout_err), .busy(busy),
    .dbg_state(dbg_state), .dbg_step_pending(dbg_step_pending)
  );

  // Clock and absolute time limit
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL sim_timeout act=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_push(input logic [W-1:0] v, input bit accept);
    push = 1'b1;
    push_instr = v;
    if (accept) exp_q.push_back(v);
    tick();
    push = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_state(input seq_state_t s, input int budget, input string tag);
    int n = 0;
    while (dbg_state != s && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (!(empty && !busy) && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(empty && !busy), 1);
  endtask

  // Scoreboard: every accepted issue must match the oldest expected instruction
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && issue_valid && issue_ready && !flush) begin
        acc_cnt++;
        check_eq("sb_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("issue_instr", 32'(issue_instr), 32'(e));
        end
      end
    end
  end

  // CPU model: completion pulse done_delay cycles after each acceptance
  initial begin
    cpu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_auto != 0 && reset_n && issue_valid && issue_ready && !flush) begin
        repeat (done_delay) @(posedge clk);
        #1 cpu_done = 1'b1;
        @(posedge clk);
        #1 cpu_done = 1'b0;
      end
    end
  end

  initial begin
    int acc0, n;
    bit ok;
    logic [W-1:0] first;

    // Reset
    tick(3);
    reset_n = 1'b1;
    tick();
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_flags", {26'd0, empty, full, overflow, timeout_err, busy, issue_valid}, 32'b100000);
    check_eq("rst_instr", 32'(issue_instr), 0);

    // Auto-run, three instructions
    run_mode = 1'b1; issue_ready = 1'b1; cpu_auto = 1; done_delay = 5;
    acc0 = acc_cnt;
    do_push(18'h04005, 1);
    do_push(18'h0880A, 1);
    do_push(18'h1C000, 1);
    wait_drain(300, "auto_drain");
    check_eq("auto_acc", 32'(acc_cnt - acc0), 3);
    check_eq("auto_count", 32'(count), 0);
    check_eq("auto_err", {30'd0, overflow, timeout_err}, 0);

    // Push into empty FIFO while idle: count at N+1, valid at N+2
    do_push(18'h2AAAA, 1);
    check_eq("lat_count", 32'(count), 1);
    check_eq("lat_valid_n1", 32'(issue_valid), 0);
    tick();
    check_eq("lat_valid_n2", 32'(issue_valid), 1);
    wait_drain(100, "lat_drain");

    // Single-step
    run_mode = 1'b0;
    acc0 = acc_cnt;
    do_push(18'h11111, 1);
    do_push(18'h22222, 1);
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      if (issue_valid) ok = 0;
      tick();
    end
    check_eq("ss_no_issue", 32'(ok), 1);
    step = 1'b1; tick(); step = 1'b0;
    tick(40);
    check_eq("ss_one_issue", 32'(acc_cnt - acc0), 1);
    check_eq("ss_count", 32'(count), 1);
    step = 1'b1; tick(); step = 1'b0;
    tick(40);
    check_eq("ss_two_issue", 32'(acc_cnt - acc0), 2);
    step = 1'b1; tick(); step = 1'b0;
    check_eq("ss_pending_empty", 32'(dbg_step_pending), 0);
    tick(10);
    check_eq("ss_empty_no_issue", 32'(acc_cnt - acc0), 2);

    // Overflow, handshake hold, wrap and full push+pop
    run_mode = 1'b1; issue_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 9; i++) do_push(W'(18'h30000 + i), i < 8);
    check_eq("ovf_full", 32'(full), 1);
    check_eq("ovf_count", 32'(count), 8);
    check_eq("ovf_flag", 32'(overflow), 1);
    first = 18'h30000;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      if (!issue_valid || issue_instr !== first || count != 4'd8) ok = 0;
      tick();
    end
    check_eq("hold_stable", 32'(ok), 1);
    issue_ready = 1'b1;
    do_push(18'h3ABCD, 1);
    check_eq("fullpop_count", 32'(count), 8);
    wait_drain(600, "wrap_drain");
    check_eq("wrap_acc", 32'(acc_cnt - acc0), 9);
    do_flush();
    check_eq("flush_ovf_clr", 32'(overflow), 0);

    // Watchdog expiry
    cpu_auto = 0;
    do_push(18'h05555, 1);
    wait_state(SEQ_WAIT, 10, "wd_enter");
    n = 0;
    while (dbg_state != SEQ_IDLE && n < 40) begin tick(); n++; end
    check_eq("wd_cycles", 32'(n), TOC);
    check_eq("wd_err", 32'(timeout_err), 1);
    do_flush();
    check_eq("wd_err_clr", 32'(timeout_err), 0);

    // cpu_done on the expiry cycle wins
    cpu_auto = 1; done_delay = TOC;
    do_push(18'h06666, 1);
    wait_state(SEQ_WAIT, 10, "wd2_enter");
    n = 0;
    while (dbg_state != SEQ_IDLE && n < 40) begin tick(); n++; end
    check_eq("wd2_cycles", 32'(n), TOC);
    check_eq("wd2_no_err", 32'(timeout_err), 0);

    // Flush during ISSUE, with issue_ready and push in the same cycle
    done_delay = 5; issue_ready = 1'b0;
    do_push(18'h07777, 1);
    do_push(18'h08888, 1);
    wait_state(SEQ_ISSUE, 10, "fl_issue_enter");
    acc0 = acc_cnt;
    flush = 1'b1; issue_ready = 1'b1; push = 1'b1; push_instr = 18'h09999;
    exp_q.delete();
    tick();
    flush = 1'b0; push = 1'b0;
    check_eq("fl_valid", 32'(issue_valid), 0);
    check_eq("fl_count", 32'(count), 0);
    check_eq("fl_ovf", 32'(overflow), 0);
    check_eq("fl_busy", 32'(busy), 0);
    check_eq("fl_no_hs", 32'(acc_cnt - acc0), 0);
    tick(5);
    check_eq("fl_stay_empty", 32'(count), 0);

    // Flush during WAIT: in-flight instruction completes normally
    done_delay = 8;
    do_push(18'h0AAAA, 1);
    wait_state(SEQ_WAIT, 10, "flw_enter");
    do_flush();
    check_eq("flw_stay", 32'(dbg_state), 32'(SEQ_WAIT));
    wait_state(SEQ_IDLE, 20, "flw_done");
    check_eq("flw_no_err", 32'(timeout_err), 0);

    // Asynchronous reset mid-ISSUE
    cpu_auto = 0; issue_ready = 1'b0;
    do_push(18'h0BBBB, 1);
    do_push(18'h0CCCC, 1);
    wait_state(SEQ_ISSUE, 10, "rst2_issue_enter");
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("rst2_flags", {26'd0, empty, full, overflow, timeout_err, busy, issue_valid}, 32'b100000);
    check_eq("rst2_count", 32'(count), 0);
    check_eq("rst2_instr", 32'(issue_instr), 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check_eq("rst2_idle", 32'(dbg_state), 32'(SEQ_IDLE));

    check_eq("sb_leftover", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction queue and issue controller placed in front of the mini-CPU execute FSM.
- Buffers 18-bit instructions pushed from the switch/button front end into a FIFO.
- Issues them one at a time to the CPU over a valid/ready handshake, then waits for the CPU's completion pulse (end of its LCD state) before issuing the next.
- Supports auto-run and single-step modes, flush, and a completion watchdog.

Parameters:
- DEPTH, 8, FIFO entries (power of two, at least 2); PTR_W = $clog2(DEPTH).
- INSTR_W, 18, instruction width; matches the SW[17:0] format.
- TIMEOUT_CYC, 1024, maximum cycles in WAIT without cpu_done before aborting.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- push  in  1  one-cycle enqueue pulse from the debounced Enviar edge detector.
- push_instr  in  INSTR_W  instruction sampled when push=1.
- run_mode  in  1  1 = auto-issue whenever the FIFO is not empty; 0 = single-step.
- step  in  1  one-cycle pulse; permits one issue in single-step mode.
- flush  in  1  one-cycle pulse; empties the queue and clears the sticky errors.
- issue_valid  out  1  instruction offered to the CPU.
- issue_instr  out  INSTR_W  offered instruction, registered.
- issue_ready  in  1  CPU idle; accepts when issue_valid and issue_ready are both 1.
- cpu_done  in  1  one-cycle pulse when the CPU returns to IDLE.
- count  out  PTR_W+1  current FIFO occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: a push was dropped.
- timeout_err  out  1  sticky: the watchdog expired.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, any state, mid-handshake included):
  - state=IDLE; FIFO pointers, count and step_pending cleared.
  - Outputs: issue_valid=0, issue_instr=0, count=0, empty=1, full=0, overflow=0, timeout_err=0, busy=0.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - Push is accepted if !full, or if a pop occurs in the same cycle. When full with a simultaneous pop, count stays at DEPTH.
  - Push while full with no pop: instruction dropped, overflow<=1.
  - A push is visible in count on the next cycle. No bypass: an instruction is issuable at the earliest one cycle after it is written.
- step_pending:
  - Set by step when the FIFO is not empty or a push is accepted in the same cycle; otherwise the step is discarded.
  - Cleared on the IDLE->ISSUE transition or on flush.
  - Ignored when run_mode=1.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when !empty and (run_mode or step_pending).
    - On this edge, issue_instr<=head and issue_valid<=1.
  - ISSUE:
    - Hold issue_valid=1 and issue_instr stable until issue_ready=1 is sampled.
    - On that edge: pop the FIFO, issue_valid<=0, go to WAIT, clear the watchdog.
  - WAIT:
    - Watchdog increments each cycle.
    - cpu_done=1 -> IDLE.
    - Else if watchdog==TIMEOUT_CYC-1 -> IDLE and timeout_err<=1.
    - cpu_done and expiry in the same cycle: done wins, no error.
  - cpu_done outside WAIT is ignored.
- Issue spacing:
  - Back-to-back issue in run mode: WAIT->IDLE->ISSUE, so issue_valid rises 2 cycles after cpu_done.
  - Push into an empty FIFO while IDLE in run mode at cycle N: count=1 at N+1, issue_valid=1 at N+2.
- flush:
  - Clears the FIFO, step_pending, overflow and timeout_err.
  - In ISSUE: go to IDLE, issue_valid<=0; no pop, because the entry has already been cleared.
  - flush with issue_ready in the same ISSUE cycle: flush wins, no handshake.
  - In WAIT: remain in WAIT; the in-flight instruction completes normally.
  - flush with push in the same cycle: push dropped, overflow not set.
- run_mode changes take effect only in IDLE; an issue already in progress completes.

Decomposition:
- Shared package (cpu_pkg):
  - Sequencer state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2).
  - INSTR_W, and opcode field position [17:15], shared with the CPU and LCD driver.
- One sub-module: seq_fifo, a synchronous FIFO with push/pop/count/full/empty and DEPTH/INSTR_W parameters.
- Watchdog, step latch and FSM stay in instr_sequencer.

Test Plan:
- Auto-run, 3 instructions: run_mode=1, push 0x04005, 0x0880A, 0x1C000 on cycles 0/1/2; issue_ready=1; cpu_done 5 cycles after each acceptance -> issue_instr sequence 0x04005, 0x0880A, 0x1C000, each accepted once; count ends at 0; no errors.
- Single-step: run_mode=0, push 2 instructions -> issue_valid stays 0 for 50 cycles; one step -> exactly one issue; a step with the FIFO empty -> no issue and step_pending=0.
- Overflow and wrap: DEPTH=8, push 9 instructions with the CPU stalled (issue_ready=0) -> full=1, count=8, overflow=1, 9th instruction lost. Then drain all 8 -> original order preserved across pointer wrap. Push while full with a simultaneous pop -> accepted, count stays 8.
- Handshake hold: issue_ready=0 for 20 cycles during ISSUE -> issue_valid=1 and issue_instr stable throughout; pop only on the cycle issue_ready=1.
- Watchdog: TIMEOUT_CYC=16, no cpu_done -> return to IDLE exactly 16 cycles after entering WAIT, timeout_err=1; cpu_done on the expiry cycle -> timeout_err stays 0.
- Flush/reset mid-operation:
  - flush during ISSUE -> issue_valid=0 next cycle, count=0, no pop.
  - flush during WAIT -> stays in WAIT until cpu_done.
  - reset_n low mid-ISSUE -> all outputs at their reset values immediately.
